mem_access_arbiter: RTL and testbench
=====================================

// Module: mem_access_arbiter
// PURPOSE
//  CPU-side initiator for the shared single-port byte memory. Arbitrates IF fetch and MEM-stage load/store
//  requests, issues word-aligned accesses with byte enables, and aligns/extends returned data. Splits
//  accesses that straddle a word boundary; one access in flight at a time.
// PARAMETERS
//  AW  9   byte-address width; all address arithmetic is modulo 2**AW
// PORTS
//  clk        in   1   clock
//  rst        in   1   reset, synchronous, active-high
//  if_req     in   1   fetch request, held high until if_valid
//  if_addr    in   AW  fetch byte address, halfword aligned (bit0 ignored)
//  if_valid   out  1   one-cycle pulse: if_rdata valid
//  if_rdata   out  32  32 bits starting at if_addr
//  ls_req     in   1   load/store request, held high (fields stable) until ls_valid
//  ls_we      in   1   1 = store
//  ls_func3   in   3   RV32 width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  ls_addr    in   AW  byte address
//  ls_wdata   in   32  store data, LSB-justified
//  ls_valid   out  1   one-cycle pulse: load data valid or store done
//  ls_rdata   out  32  aligned, extended load data; 0 for stores
//  ls_err     out  1   pulses with ls_valid: illegal func3 or (macro off) misaligned
//  m_addr     out  AW  word-aligned byte address, [1:0] = 0
//  m_re       out  1   read strobe
//  m_we       out  1   write strobe
//  m_be       out  4   byte enables, bit i = byte addr+i
//  m_wdata    out  32  lane-shifted write data
//  m_rdata    in   32  read data, valid the cycle after m_re
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; in-flight access dropped, no valid/err pulse.
//  - FSM IDLE -> ACC1 -> (ACC2 if split) -> DONE -> IDLE. m_* registered, nonzero only in ACC1/ACC2.
//  - IDLE: grant ls over if when both pending; a requester whose valid pulses this cycle is masked.
//  - ACC1 drives first (aligned) word; ACC2 drives addr+4 (wraps), first word captured; DONE captures last word.
//  - Latency, req sampled cycle 0: unsplit valid in cycle 3; split valid in cycle 4.
//  - Split: fetch with if_addr[1]=1 always; LH/LHU/SH with addr[1:0]=3; LW/SW with addr[1:0]!=0.
//  - Store lanes: off=addr[1:0]; SB be=0001<<off; SH be=0011<<off; SW be=1111; m_wdata = wdata<<(8*off),
//    split stores put remaining bytes in ACC2 with the matching be.
//  - Load: select bytes at off from the merged 64-bit {word2,word1}; sign-extend for B/H, zero-extend for BU/HU.
//  - Illegal func3 (011,110,111, or stores with 1xx): no memory access; ls_err=1, ls_rdata=0, valid in cycle 2.
// CONFIGURATION
//  MISALIGN_SPLIT_EN defined: misaligned ls accesses split as above.
//  Undefined: misaligned ls -> no m_re/m_we, ls_err=1, ls_rdata=0, valid in cycle 2. Fetch split unaffected.
// STRUCTURE
//  Package mem_arb_pkg: state enum (IDLE, ACC1, ACC2, DONE), func3 constants, be_for(func3,off) function.
//  Sub-module lane_align: combinational store shift/be and load select/extend, shared by both paths.
// TESTING
//  1 LW 0x0C4, word=0x80000021 -> ls_rdata 0x80000021, ls_valid cycle 3, ls_err 0.
//  2 LB 0x0CB, byte=0xF0 -> 0xFFFFFFF0; LBU same -> 0x000000F0.
//  3 SH 0x0CA, wdata 0x1234ABCD -> ACC1 m_be 1100, m_wdata 0xABCD0000, m_addr 0x0C8.
//  4 if_req+ls_req cycle 0 (LW 0x0C4, fetch 0x010) -> ls_valid cycle 3; if_valid cycle 6.
//  5 fetch 0x03A, [0x038]=0xAAAA1111, [0x03C]=0x2222BBBB -> if_rdata 0xBBBBAAAA, if_valid cycle 4.
//  6 LW 0x0C5: EN -> two reads, merged bytes 0x0C5..0x0C8, valid cycle 4; no EN -> ls_err 1, no m_re;
//    rst in ACC1 -> outputs 0, no valid pulse.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory access arbiter: FSM states,
// RV32 load/store width codes and byte-enable generation.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC1 = 2'd1,
    ACC2 = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // 8-bit enable across the two words touched; [7:4] nonzero means a split access.
  function automatic logic [7:0] be_for(input logic [2:0] func3, input logic [1:0] off);
    logic [7:0] base;
    case (func3[1:0])
      2'b00:   base = 8'h01;
      2'b01:   base = 8'h03;
      default: base = 8'h0F;
    endcase
    return base << off;
  endfunction

  function automatic logic f3_legal(input logic [2:0] func3, input logic we);
    logic ok;
    case (func3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic misaligned(input logic [2:0] func3, input logic [1:0] off);
    logic mis;
    case (func3[1:0])
      2'b01:   mis = off[0];
      2'b10:   mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_arbiter_lane_align.sv
// Combinational lane steering: store shift / byte enables and load
// byte select with sign or zero extension, shared by fetch and load/store.
module lane_align
  import mem_arb_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [63:0] rdata64,
  output logic [7:0]  be,
  output logic [63:0] wdata64,
  output logic [31:0] rdata
);

  logic [31:0] sel;

  always_comb begin
    be      = be_for(func3, off);
    wdata64 = {32'h0, wdata} << {off, 3'b000};
    sel     = 32'(rdata64 >> {off, 3'b000});
    case (func3)
      F3_B:    rdata = {{24{sel[7]}}, sel[7:0]};
      F3_H:    rdata = {{16{sel[15]}}, sel[15:0]};
      F3_BU:   rdata = {24'h0, sel[7:0]};
      F3_HU:   rdata = {16'h0, sel[15:0]};
      default: rdata = sel;
    endcase
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// CPU-side initiator for the shared byte memory: arbitrates fetch and load/store,
// splits word-straddling accesses. MISALIGN_SPLIT_EN enables split load/store.
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_valid,
  output logic [31:0]   if_rdata,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [2:0]    ls_func3,
  input  logic [AW-1:0] ls_addr,
  input  logic [31:0]   ls_wdata,
  output logic          ls_valid,
  output logic [31:0]   ls_rdata,
  output logic          ls_err,
  output logic [AW-1:0] m_addr,
  output logic          m_re,
  output logic          m_we,
  output logic [3:0]    m_be,
  output logic [31:0]   m_wdata,
  input  logic [31:0]   m_rdata
);

  state_t state_q, state_d;

  logic          ls_pend, if_pend, grant_ls, grant_if;
  logic          misalign_err, req_err, req_split;
  logic [AW-1:0] req_addr, req_word;

  logic [2:0]    la_func3;
  logic [1:0]    la_off;
  logic [7:0]    la_be;
  logic [63:0]   la_wdata, la_rdata64;
  logic [31:0]   la_rdata;

  logic          is_ls_q, we_q, err_q, split_q;
  logic [2:0]    func3_q;
  logic [1:0]    off_q;
  logic [AW-1:0] addr_hi_q;
  logic [3:0]    be_hi_q;
  logic [31:0]   wdata_hi_q, word1_q;

  logic          unused_if_bit;
  assign unused_if_bit = if_addr[0];

  always_comb begin
    ls_pend  = ls_req & ~ls_valid;
    if_pend  = if_req & ~if_valid;
    grant_ls = (state_q == IDLE) & ls_pend;
    grant_if = (state_q == IDLE) & if_pend & ~ls_pend;
    req_addr = grant_ls ? ls_addr : if_addr;
    req_word = {req_addr[AW-1:2], 2'b00};

    // lane_align sees the incoming request in IDLE, the latched one afterwards
    if (state_q == IDLE) begin
      la_func3 = ls_pend ? ls_func3 : F3_W;
      la_off   = ls_pend ? ls_addr[1:0] : {if_addr[1], 1'b0};
    end else begin
      la_func3 = func3_q;
      la_off   = off_q;
    end
    la_rdata64 = split_q ? {m_rdata, word1_q} : {32'h0, m_rdata};

`ifdef MISALIGN_SPLIT_EN
    misalign_err = 1'b0;
`else
    misalign_err = misaligned(ls_func3, ls_addr[1:0]);
`endif
    req_err   = grant_ls & (~f3_legal(ls_func3, ls_we) | misalign_err);
    req_split = |la_be[7:4];
  end

  lane_align u_lane_align (
    .func3   (la_func3),
    .off     (la_off),
    .wdata   (ls_wdata),
    .rdata64 (la_rdata64),
    .be      (la_be),
    .wdata64 (la_wdata),
    .rdata   (la_rdata)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_ls | grant_if) state_d = req_err ? DONE : ACC1;
      ACC1:    state_d = split_q ? ACC2 : DONE;
      ACC2:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_addr     <= '0;
      m_re       <= 1'b0;
      m_we       <= 1'b0;
      m_be       <= '0;
      m_wdata    <= '0;
      if_valid   <= 1'b0;
      if_rdata   <= '0;
      ls_valid   <= 1'b0;
      ls_rdata   <= '0;
      ls_err     <= 1'b0;
      is_ls_q    <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      split_q    <= 1'b0;
      func3_q    <= '0;
      off_q      <= '0;
      addr_hi_q  <= '0;
      be_hi_q    <= '0;
      wdata_hi_q <= '0;
      word1_q    <= '0;
    end else begin
      m_addr   <= '0;
      m_re     <= 1'b0;
      m_we     <= 1'b0;
      m_be     <= '0;
      m_wdata  <= '0;
      if_valid <= 1'b0;
      ls_valid <= 1'b0;
      ls_err   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_ls | grant_if) begin
            is_ls_q    <= grant_ls;
            we_q       <= grant_ls & ls_we;
            err_q      <= req_err;
            split_q    <= req_split & ~req_err;
            func3_q    <= la_func3;
            off_q      <= la_off;
            addr_hi_q  <= req_word + AW'(4);
            be_hi_q    <= la_be[7:4];
            wdata_hi_q <= la_wdata[63:32];
            if (!req_err) begin
              m_addr  <= req_word;
              m_re    <= ~(grant_ls & ls_we);
              m_we    <= grant_ls & ls_we;
              m_be    <= (grant_ls & ls_we) ? la_be[3:0] : 4'hF;
              m_wdata <= (grant_ls & ls_we) ? la_wdata[31:0] : '0;
            end
          end
        end
        ACC1: begin
          if (split_q) begin
            m_addr  <= addr_hi_q;
            m_re    <= ~we_q;
            m_we    <= we_q;
            m_be    <= we_q ? be_hi_q : 4'hF;
            m_wdata <= we_q ? wdata_hi_q : '0;
          end
        end
        ACC2: word1_q <= m_rdata;
        DONE: begin
          if (is_ls_q) begin
            ls_valid <= 1'b1;
            ls_err   <= err_q;
            ls_rdata <= (err_q | we_q) ? '0 : la_rdata;
          end else begin
            if_valid <= 1'b1;
            if_rdata <= la_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter with a byte-memory model; honours MISALIGN_SPLIT_EN.
module tb_mem_access_arbiter;

  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, ls_req, ls_we;
  logic [AW-1:0] if_addr, ls_addr;
  logic [2:0]    ls_func3;
  logic [31:0]   ls_wdata;
  logic          if_valid, ls_valid, ls_err;
  logic [31:0]   if_rdata, ls_rdata;
  logic [AW-1:0] m_addr;
  logic          m_re, m_we;
  logic [3:0]    m_be;
  logic [31:0]   m_wdata;
  logic [31:0]   m_rdata = '0;

  mem_access_arbiter #(.AW(AW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_func3(ls_func3), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_valid(ls_valid), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .m_addr(m_addr), .m_re(m_re), .m_we(m_we), .m_be(m_be), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:511];

  always @(posedge clk) begin
    if (m_re)
      m_rdata <= {mem[9'(m_addr + 3)], mem[9'(m_addr + 2)], mem[9'(m_addr + 1)], mem[m_addr]};
    if (m_we)
      for (int i = 0; i < 4; i++)
        if (m_be[i]) mem[9'(m_addr + i)] <= m_wdata[8*i +: 8];
  end

  int n_chk = 0;
  int n_fail = 0;

  int          r_cyc, n_re, n_we, n_acc;
  logic [31:0] r_rdata, w_data1;
  logic        r_err;
  logic [3:0]  w_be1;
  logic [8:0]  a_first, a_last;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_word(input logic [8:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) mem[9'(a + i)] = w[8*i +: 8];
  endtask

  // Issues one request on a negedge; cycle c is the c-th negedge after it.
  task automatic run_acc(input logic fetch, input logic we, input logic [2:0] f3,
                         input logic [8:0] addr, input logic [31:0] wd);
    @(negedge clk);
    if (fetch) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      ls_req = 1'b1; ls_we = we; ls_func3 = f3; ls_addr = addr; ls_wdata = wd;
    end
    r_cyc = -1; n_re = 0; n_we = 0; n_acc = 0;
    r_rdata = 'x; r_err = 1'bx; w_be1 = 'x; w_data1 = 'x; a_first = 'x; a_last = 'x;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (m_re | m_we) begin
        if (n_acc == 0) a_first = m_addr;
        a_last = m_addr;
        n_acc++;
      end
      if (m_re) n_re++;
      if (m_we) begin
        if (n_we == 0) begin w_be1 = m_be; w_data1 = m_wdata; end
        n_we++;
      end
      if (fetch ? if_valid : ls_valid) begin
        r_cyc = c;
        r_rdata = fetch ? if_rdata : ls_rdata;
        r_err = fetch ? 1'b0 : ls_err;
        break;
      end
    end
    if_req = 1'b0;
    ls_req = 1'b0;
    chk("timeout", 32'(r_cyc >= 0), 32'd1);
  endtask

  int          lsc, ifc, vcount;
  logic [31:0] lsd, ifd;
  logic        drop_ls;

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0;
    ls_func3 = '0; ls_addr = '0; ls_wdata = '0;
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    set_word(9'h0C4, 32'h80000021);
    set_word(9'h0C8, 32'hF0000055);
    set_word(9'h010, 32'h13579BDF);
    set_word(9'h038, 32'hAAAA1111);
    set_word(9'h03C, 32'h2222BBBB);
    set_word(9'h1FC, 32'h56780000);
    set_word(9'h000, 32'h00001234);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_outs", {m_re, m_we, m_be, ls_valid, if_valid, ls_err}, '0);
    chk("rst_maddr", 32'(m_addr), 32'h0);
    chk("rst_rdata", ls_rdata | if_rdata | m_wdata, 32'h0);

    // LW aligned
    run_acc(1'b0, 1'b0, 3'b010, 9'h0C4, '0);
    chk("lw_data", r_rdata, 32'h80000021);
    chk("lw_cyc", 32'(r_cyc), 32'd3);
    chk("lw_err", 32'(r_err), 32'd0);
    chk("lw_addr", 32'(a_first), 32'h0C4);
    chk("lw_nre", 32'(n_re), 32'd1);

    // LB / LBU
    run_acc(1'b0, 1'b0, 3'b000, 9'h0CB, '0);
    chk("lb_data", r_rdata, 32'hFFFFFFF0);
    run_acc(1'b0, 1'b0, 3'b100, 9'h0CB, '0);
    chk("lbu_data", r_rdata, 32'h000000F0);

    // SH upper half, then read back
    run_acc(1'b0, 1'b1, 3'b001, 9'h0CA, 32'h1234ABCD);
    chk("sh_be", 32'(w_be1), 32'hC);
    chk("sh_wdata", w_data1, 32'hABCD0000);
    chk("sh_addr", 32'(a_first), 32'h0C8);
    chk("sh_cyc", 32'(r_cyc), 32'd3);
    chk("sh_rdata", r_rdata, 32'h0);
    chk("sh_nwe", 32'(n_we), 32'd1);
    run_acc(1'b0, 1'b0, 3'b101, 9'h0CA, '0);
    chk("lhu_data", r_rdata, 32'h0000ABCD);
    run_acc(1'b0, 1'b0, 3'b001, 9'h0CA, '0);
    chk("lh_data", r_rdata, 32'hFFFFABCD);

    // SB lane 1
    run_acc(1'b0, 1'b1, 3'b000, 9'h0C9, 32'h00000077);
    chk("sb_be", 32'(w_be1), 32'h2);
    chk("sb_wdata", w_data1, 32'h00007700);
    run_acc(1'b0, 1'b0, 3'b100, 9'h0C9, '0);
    chk("sb_rb", r_rdata, 32'h00000077);

    // Both requesters in the same cycle; ls_req held one cycle past its valid
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b0; ls_func3 = 3'b010; ls_addr = 9'h0C4;
    if_req = 1'b1; if_addr = 9'h010;
    lsc = -1; ifc = -1; lsd = 'x; ifd = 'x; drop_ls = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (drop_ls) begin ls_req = 1'b0; drop_ls = 1'b0; end
      if (ls_valid && lsc < 0) begin lsc = c; lsd = ls_rdata; drop_ls = 1'b1; end
      if (if_valid) begin ifc = c; ifd = if_rdata; break; end
    end
    ls_req = 1'b0; if_req = 1'b0;
    chk("arb_ls_cyc", 32'(lsc), 32'd3);
    chk("arb_ls_data", lsd, 32'h80000021);
    chk("arb_if_cyc", 32'(ifc), 32'd6);
    chk("arb_if_data", ifd, 32'h13579BDF);

    // Split fetch and wrapping split fetch
    run_acc(1'b1, 1'b0, 3'b010, 9'h03A, '0);
    chk("fsplit_data", r_rdata, 32'hBBBBAAAA);
    chk("fsplit_cyc", 32'(r_cyc), 32'd4);
    chk("fsplit_nre", 32'(n_re), 32'd2);
    run_acc(1'b1, 1'b0, 3'b010, 9'h1FE, '0);
    chk("fwrap_data", r_rdata, 32'h12345678);
    chk("fwrap_addr2", 32'(a_last), 32'h000);

    // Illegal func3
    run_acc(1'b0, 1'b0, 3'b011, 9'h0C4, '0);
    chk("ill_ld_err", 32'(r_err), 32'd1);
    chk("ill_ld_cyc", 32'(r_cyc), 32'd2);
    chk("ill_ld_rdata", r_rdata, 32'h0);
    chk("ill_ld_nacc", 32'(n_acc), 32'd0);
    run_acc(1'b0, 1'b1, 3'b100, 9'h0C4, 32'hFFFFFFFF);
    chk("ill_st_err", 32'(r_err), 32'd1);
    chk("ill_st_nwe", 32'(n_we), 32'd0);

    // Misaligned loads
    run_acc(1'b0, 1'b0, 3'b010, 9'h0C5, '0);
`ifdef MISALIGN_SPLIT_EN
    chk("mis_lw_data", r_rdata, 32'h55800000);
    chk("mis_lw_cyc", 32'(r_cyc), 32'd4);
    chk("mis_lw_nre", 32'(n_re), 32'd2);
    chk("mis_lw_err", 32'(r_err), 32'd0);
`else
    chk("mis_lw_err", 32'(r_err), 32'd1);
    chk("mis_lw_cyc", 32'(r_cyc), 32'd2);
    chk("mis_lw_nre", 32'(n_re), 32'd0);
    chk("mis_lw_rdata", r_rdata, 32'h0);
`endif
    run_acc(1'b0, 1'b0, 3'b001, 9'h0C7, '0);
`ifdef MISALIGN_SPLIT_EN
    chk("mis_lh_data", r_rdata, 32'h00005580);
    chk("mis_lh_cyc", 32'(r_cyc), 32'd4);
`else
    chk("mis_lh_err", 32'(r_err), 32'd1);
    chk("mis_lh_rdata", r_rdata, 32'h0);
`endif

    // Reset while in ACC1
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b0; ls_func3 = 3'b010; ls_addr = 9'h0C4;
    @(negedge clk);
    chk("racc1_mre", 32'(m_re), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("racc1_outs", {m_re, m_we, m_be, ls_valid, ls_err}, '0);
    chk("racc1_maddr", 32'(m_addr), 32'h0);
    rst = 1'b0; ls_req = 1'b0;
    vcount = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ls_valid | if_valid | m_re) vcount++;
    end
    chk("racc1_quiet", 32'(vcount), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
